// File: rtl/hilo_issue_queue.sv
// In-order issue queue for the HI/LO functional unit, capturing late GPR and HI/LO operands.
// Optional HILO_IQ_BYPASS_EN: an empty queue issues a fully ready dispatch in the same cycle.
`ifndef INST_STATE_WD
`define INST_STATE_WD 8
`endif

module hilo_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_WD = 6
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [11:0]               in_op,
    input  logic [`INST_STATE_WD-1:0] in_inst_status,
    input  logic                      in_src1_rdy,
    input  logic [TAG_WD-1:0]         in_src1_tag,
    input  logic [31:0]               in_src1_data,
    input  logic                      in_src2_rdy,
    input  logic [TAG_WD-1:0]         in_src2_tag,
    input  logic [63:0]               in_src2_data,
    input  logic                      gpr_wb_valid,
    input  logic [TAG_WD-1:0]         gpr_wb_tag,
    input  logic [31:0]               gpr_wb_data,
    input  logic                      hilo_wb_valid,
    input  logic [TAG_WD-1:0]         hilo_wb_tag,
    input  logic [63:0]               hilo_wb_data,
    input  logic                      fu_busy,
    output logic                      issue,
    output logic [11:0]               issue_op,
    output logic [`INST_STATE_WD-1:0] issue_inst_status,
    output logic [31:0]               issue_rdata1,
    output logic [63:0]               issue_rdata2,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PTR_WD = $clog2(DEPTH);
    localparam int CNT_WD = PTR_WD + 1;
    localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DEPTH);
    localparam logic [CNT_WD-1:0] CNT_ONE  = CNT_WD'(1);
    localparam logic [PTR_WD-1:0] PTR_ONE  = PTR_WD'(1);

    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [DEPTH-1:0]          s1_rdy_q, s1_rdy_d;
    logic [DEPTH-1:0]          s2_rdy_q, s2_rdy_d;
    logic [11:0]               op_q      [DEPTH];
    logic [11:0]               op_d      [DEPTH];
    logic [`INST_STATE_WD-1:0] st_q      [DEPTH];
    logic [`INST_STATE_WD-1:0] st_d      [DEPTH];
    logic [TAG_WD-1:0]         s1_tag_q  [DEPTH];
    logic [TAG_WD-1:0]         s1_tag_d  [DEPTH];
    logic [TAG_WD-1:0]         s2_tag_q  [DEPTH];
    logic [TAG_WD-1:0]         s2_tag_d  [DEPTH];
    logic [31:0]               s1_data_q [DEPTH];
    logic [31:0]               s1_data_d [DEPTH];
    logic [63:0]               s2_data_q [DEPTH];
    logic [63:0]               s2_data_d [DEPTH];
    logic [PTR_WD-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CNT_WD-1:0]         count_q, count_d;

    logic        in_s1_rdy, in_s2_rdy;
    logic [31:0] in_s1_data;
    logic [63:0] in_s2_data;
    logic        head_rdy, pop, push, bypass;

    assign in_ready = (count_q != FULL_CNT) & ~flush;
    assign count    = count_q;

    // A broadcast in the dispatch cycle is folded into the operands being written.
    assign in_s1_rdy  = in_src1_rdy | (gpr_wb_valid & (gpr_wb_tag == in_src1_tag));
    assign in_s1_data = in_src1_rdy ? in_src1_data : gpr_wb_data;
    assign in_s2_rdy  = in_src2_rdy | (hilo_wb_valid & (hilo_wb_tag == in_src2_tag));
    assign in_s2_data = in_src2_rdy ? in_src2_data : hilo_wb_data;

    assign head_rdy = valid_q[head_q] & s1_rdy_q[head_q] & s2_rdy_q[head_q];
    assign pop      = head_rdy & ~fu_busy & ~flush;
`ifdef HILO_IQ_BYPASS_EN
    assign bypass   = (count_q == '0) & in_valid & in_s1_rdy & in_s2_rdy & ~fu_busy & ~flush;
`else
    assign bypass   = 1'b0;
`endif
    assign push     = in_valid & in_ready & ~bypass;
    assign issue    = pop | bypass;

    always_comb begin
        issue_op          = '0;
        issue_inst_status = '0;
        issue_rdata1      = '0;
        issue_rdata2      = '0;
        if (pop) begin
            issue_op          = op_q[head_q];
            issue_inst_status = st_q[head_q];
            issue_rdata1      = s1_data_q[head_q];
            issue_rdata2      = s2_data_q[head_q];
        end
`ifdef HILO_IQ_BYPASS_EN
        else if (bypass) begin
            issue_op          = in_op;
            issue_inst_status = in_inst_status;
            issue_rdata1      = in_s1_data;
            issue_rdata2      = in_s2_data;
        end
`endif
    end

    // NOTE: every _d signal takes its _q value first, so no path through this block infers a latch.
    always_comb begin
        valid_d   = valid_q;
        s1_rdy_d  = s1_rdy_q;
        s2_rdy_d  = s2_rdy_q;
        op_d      = op_q;
        st_d      = st_q;
        s1_tag_d  = s1_tag_q;
        s2_tag_d  = s2_tag_q;
        s1_data_d = s1_data_q;
        s2_data_d = s2_data_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] & ~s1_rdy_q[i] & gpr_wb_valid & (gpr_wb_tag == s1_tag_q[i])) begin
                s1_rdy_d[i]  = 1'b1;
                s1_data_d[i] = gpr_wb_data;
            end
            if (valid_q[i] & ~s2_rdy_q[i] & hilo_wb_valid & (hilo_wb_tag == s2_tag_q[i])) begin
                s2_rdy_d[i]  = 1'b1;
                s2_data_d[i] = hilo_wb_data;
            end
        end

        // Push and pop never share a slot: push needs a non-full queue, pop a non-empty one.
        if (push) begin
            valid_d[tail_q]   = 1'b1;
            op_d[tail_q]      = in_op;
            st_d[tail_q]      = in_inst_status;
            s1_rdy_d[tail_q]  = in_s1_rdy;
            s1_tag_d[tail_q]  = in_src1_tag;
            s1_data_d[tail_q] = in_s1_data;
            s2_rdy_d[tail_q]  = in_s2_rdy;
            s2_tag_d[tail_q]  = in_src2_tag;
            s2_data_d[tail_q] = in_s2_data;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
        end

        head_d = pop  ? head_q + PTR_ONE : head_q;
        tail_d = push ? tail_q + PTR_ONE : tail_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry payload is left unreset; nothing reads it unless its valid bit is set.
    always_ff @(posedge clk) begin
        s1_rdy_q  <= s1_rdy_d;
        s2_rdy_q  <= s2_rdy_d;
        op_q      <= op_d;
        st_q      <= st_d;
        s1_tag_q  <= s1_tag_d;
        s2_tag_q  <= s2_tag_d;
        s1_data_q <= s1_data_d;
        s2_data_q <= s2_data_d;
    end

endmodule
